// File: rtl/seg_pkg.sv
// Shared definitions for the 4-digit multiplexed 7-segment display.
// Holds the active-low segment patterns {g,f,e,d,c,b,a} for the decimal
// digits, the "everything dark" codes for segments and anodes, and the
// BCD digit type used throughout the display path.
package seg_pkg;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [3:0] AN_OFF  = 4'b1111;

endpackage

// File: rtl/seg_display_scan_bcd_to_seg.sv
// Combinational BCD to 7-segment decoder for a common-anode display.
// Ports:
//   bcd  in  4  BCD digit; codes above 9 are treated as invalid
//   seg  out 7  active-low segment pattern {g,f,e,d,c,b,a}
// Invalid codes decode to all segments dark rather than a garbage glyph.
module bcd_to_seg
  import seg_pkg::*;
(
  input  digit_t     bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_display_scan.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// The four BCD digits are captured together at the end of every scan frame,
// so one frame never mixes old and new values. Supports leading-zero
// blanking, per-digit decimal points and whole-display blinking.
// Ports:
//   clk        in   1  system clock
//   rst        in   1  synchronous reset, active-high
//   time0..3   in   4  BCD digits, time0 = rightmost (LSD), time3 = leftmost
//   blank_lead in   1  blank leading zeros on digits 3..1
//   dp_sel     in   4  dp_sel[i] lights the decimal point of digit i (live)
//   blink_en   in   1  blink the whole display every BLINK_FRAMES frames
//   an         out  4  digit enables, active-low
//   seg        out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp         out  1  decimal point, active-low
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int DIV_W        = 17,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  digit_t     time0,
  input  digit_t     time1,
  input  digit_t     time2,
  input  digit_t     time3,
  input  logic       blank_lead,
  input  logic [3:0] dp_sel,
  input  logic       blink_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  digit_t           snap [4];
  logic [FC_W-1:0]  frame_cnt;
  logic             blink_ph;

  logic             tick;
  logic             frame_end;
  logic             blk1, blk2, blk3;
  logic             cur_blank;
  digit_t           cur_digit;
  logic [6:0]       dec_seg;

  assign tick      = (div == DIV_W'(REFRESH_DIV - 1));
  assign frame_end = tick && (idx == 2'd3);

  // Scan state: divider, digit index, frame snapshot and blink timing.
  // The snapshot, index wrap and frame counter all move on the same edge
  // at frame end so the next frame starts from a consistent picture.
  always_ff @(posedge clk) begin
    if (rst) begin
      div       <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      blink_ph  <= 1'b0;
      for (int i = 0; i < 4; i++) snap[i] <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) idx <= idx + 2'd1;
      if (frame_end) begin
        snap[0] <= time0;
        snap[1] <= time1;
        snap[2] <= time2;
        snap[3] <= time3;
        if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // A digit is blanked only when it and every digit to its left are zero.
  assign blk3 = blank_lead && (snap[3] == 4'd0);
  assign blk2 = blk3 && (snap[2] == 4'd0);
  assign blk1 = blk2 && (snap[1] == 4'd0);

  always_comb begin
    cur_digit = snap[idx];
    cur_blank = 1'b0;
    case (idx)
      2'd1:    cur_blank = blk1;
      2'd2:    cur_blank = blk2;
      2'd3:    cur_blank = blk3;
      default: cur_blank = 1'b0;
    endcase
  end

  bcd_to_seg u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // Registered outputs. The anodes stay dark for the first cycle of each
  // slot so the previous digit's segments never flash on the new digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      if ((div == '0) || (blink_en && blink_ph)) an <= AN_OFF;
      else                                       an <= ~(4'b0001 << idx);
      seg <= cur_blank ? SEG_OFF : dec_seg;
      dp  <= ~dp_sel[idx];
    end
  end

endmodule
